// File: rtl/pong_pkg.sv
// Shared types and LED pattern helper for the ball-track driver.
package pong_pkg;

  typedef enum logic [2:0] {IDLE, SERVE, MOVE_A, MOVE_B, LOST} state_e;
  typedef enum logic {PLAYER_A, PLAYER_B} player_e;

  localparam int unsigned MAX_LEDS = 64;

  // Idle shows both ends lit; lost shows all-off for A, all-on for B.
  function automatic logic [MAX_LEDS-1:0] led_pattern(input state_e st, input player_e loser,
                                                      input int unsigned n);
    logic [MAX_LEDS-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < MAX_LEDS; i++) begin
      if (i < n) begin
        if (st == LOST) p[i] = (loser == PLAYER_B);
        else            p[i] = (i == 0) || (i == n - 1);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/pong_led_track_step_gen.sv
// Turns the game tick into ball-step pulses; with SPEEDUP_EN the step period shrinks per return.
module pong_step_gen #(
  parameter int unsigned INIT_PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_load,
  input  logic i_ret,
  output logic o_step
);

`ifdef SPEEDUP_EN
  localparam int unsigned CW = $clog2(INIT_PERIOD + 1);

  logic [CW-1:0] r_period;
  logic [CW-1:0] r_count;
  logic          w_fire;

  assign w_fire = i_tick && (r_count == r_period - 1'b1);
  assign o_step = w_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= CW'(INIT_PERIOD);
      r_count  <= '0;
    end else if (i_load) begin
      r_period <= CW'(INIT_PERIOD);
      r_count  <= '0;
    end else begin
      if (i_tick) r_count <= w_fire ? '0 : r_count + 1'b1;
      if (i_ret && (r_period > CW'(1))) r_period <= r_period - 1'b1;
    end
  end
`else
  logic [31:0] w_unused_period;
  logic        w_unused;

  assign w_unused_period = INIT_PERIOD;
  assign w_unused        = ^{clk, rst_n, i_load, i_ret, w_unused_period};
  assign o_step          = i_tick;
`endif

endmodule

// File: rtl/pong_led_track.sv
// Table-tennis ball track: rally FSM, position, paddle latches and LED decode.
// Optional SPEEDUP_EN macro enables per-return speedup inside pong_step_gen.
module pong_led_track
  import pong_pkg::*;
#(
  parameter int unsigned N_LEDS      = 6,
  parameter int unsigned LOST_TICKS  = 4,
  parameter int unsigned INIT_PERIOD = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic                      on,
  input  logic                      hit_a,
  input  logic                      hit_b,
  output logic [N_LEDS-1:0]         led,
  output logic [$clog2(N_LEDS)-1:0] pos,
  output logic                      lost_a,
  output logic                      lost_b
);

  localparam int unsigned PW = $clog2(N_LEDS);
  localparam int unsigned LW = $clog2(LOST_TICKS + 1);
  localparam logic [PW-1:0] LAST = PW'(N_LEDS - 1);
  localparam logic [MAX_LEDS-1:0] IDLE_PAT = led_pattern(IDLE, PLAYER_A, N_LEDS);

  state_e        r_state, w_state_d;
  player_e       r_loser, w_loser_d;
  logic [PW-1:0] r_pos, w_pos_d;
  logic [LW-1:0] r_lcnt, w_lcnt_d;
  logic          r_latch_a, r_latch_b, w_latch_a_d, w_latch_b_d;
  logic          w_hit_a, w_hit_b, w_step, w_load, w_ret;

  logic [N_LEDS-1:0]   r_led, w_led_d;
  logic [MAX_LEDS-1:0] w_pattern;
  logic                r_lost_a, r_lost_b, w_lost_a_d, w_lost_b_d;

  pong_step_gen #(
    .INIT_PERIOD(INIT_PERIOD)
  ) u_step_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .i_tick(tick),
    .i_load(w_load),
    .i_ret (w_ret),
    .o_step(w_step)
  );

  // A press on the judging tick itself counts.
  assign w_hit_a = r_latch_a | hit_a;
  assign w_hit_b = r_latch_b | hit_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_loser   <= PLAYER_A;
      r_pos     <= '0;
      r_lcnt    <= '0;
      r_latch_a <= 1'b0;
      r_latch_b <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_loser   <= w_loser_d;
      r_pos     <= w_pos_d;
      r_lcnt    <= w_lcnt_d;
      r_latch_a <= w_latch_a_d;
      r_latch_b <= w_latch_b_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_loser_d   = r_loser;
    w_pos_d     = r_pos;
    w_lcnt_d    = r_lcnt;
    w_latch_a_d = w_step ? 1'b0 : w_hit_a;
    w_latch_b_d = w_step ? 1'b0 : w_hit_b;
    w_load      = 1'b0;
    w_ret       = 1'b0;
    if (!on) begin
      w_state_d   = IDLE;
      w_pos_d     = '0;
      w_lcnt_d    = '0;
      w_latch_a_d = 1'b0;
      w_latch_b_d = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_d = SERVE;
          w_pos_d   = (r_loser == PLAYER_A) ? '0 : LAST;
          w_load    = 1'b1;
        end
        SERVE: begin
          if (w_step && (r_loser == PLAYER_A) && w_hit_a) begin
            w_state_d = MOVE_B;
            w_pos_d   = r_pos + 1'b1;
          end else if (w_step && (r_loser == PLAYER_B) && w_hit_b) begin
            w_state_d = MOVE_A;
            w_pos_d   = r_pos - 1'b1;
          end
        end
        MOVE_B: begin
          if (w_step) begin
            if (r_pos != LAST) begin
              w_pos_d = r_pos + 1'b1;
            end else if (w_hit_b) begin
              w_state_d = MOVE_A;
              w_pos_d   = r_pos - 1'b1;
              w_ret     = 1'b1;
            end else begin
              w_state_d = LOST;
              w_loser_d = PLAYER_B;
              w_lcnt_d  = '0;
            end
          end
        end
        MOVE_A: begin
          if (w_step) begin
            if (r_pos != '0) begin
              w_pos_d = r_pos - 1'b1;
            end else if (w_hit_a) begin
              w_state_d = MOVE_B;
              w_pos_d   = r_pos + 1'b1;
              w_ret     = 1'b1;
            end else begin
              w_state_d = LOST;
              w_loser_d = PLAYER_A;
              w_lcnt_d  = '0;
            end
          end
        end
        LOST: begin
          if (tick) begin
            if (r_lcnt == LW'(LOST_TICKS - 1)) begin
              w_state_d = SERVE;
              w_pos_d   = (r_loser == PLAYER_A) ? '0 : LAST;
              w_lcnt_d  = '0;
              w_load    = 1'b1;
            end else begin
              w_lcnt_d = r_lcnt + 1'b1;
            end
          end
        end
        default: w_state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from next-state values so they register alongside the state.
  always_comb begin
    w_pattern  = led_pattern(w_state_d, w_loser_d, N_LEDS);
    w_led_d    = '0;
    if ((w_state_d == IDLE) || (w_state_d == LOST)) w_led_d = w_pattern[N_LEDS-1:0];
    else                                            w_led_d[w_pos_d] = 1'b1;
    w_lost_a_d = (w_state_d == LOST) && (w_loser_d == PLAYER_A);
    w_lost_b_d = (w_state_d == LOST) && (w_loser_d == PLAYER_B);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led    <= IDLE_PAT[N_LEDS-1:0];
      r_lost_a <= 1'b0;
      r_lost_b <= 1'b0;
    end else begin
      r_led    <= w_led_d;
      r_lost_a <= w_lost_a_d;
      r_lost_b <= w_lost_b_d;
    end
  end

  assign led    = r_led;
  assign pos    = r_pos;
  assign lost_a = r_lost_a;
  assign lost_b = r_lost_b;

endmodule
